config_frame_sink: RTL and testbench
====================================

CONFIG_FRAME_SINK -- requirements
Module: config_frame_sink

Interface
REQ-001 SHALL have parameter WORD_W, default 224: configuration word width.
REQ-002 SHALL have parameter NUM_FRAMES, default 245: frame count, equal to the one-hot enable width.
REQ-003 SHALL have parameter HOLD_CYCLES, default 20: settle cycles between load completion and ff_en assertion.
REQ-004 SHALL have port clock  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port cfg_in  in  WORD_W: configuration word from the loader.
REQ-007 SHALL have port cfg_en  in  NUM_FRAMES: one-hot frame select; shifts left one position per frame.
REQ-008 SHALL have port frames_out  out  NUM_FRAMES*WORD_W: stored frames; frame k occupies bits [k*WORD_W +: WORD_W].
REQ-009 SHALL have port ff_en  out  1: fabric flip-flop enable.
REQ-010 SHALL have port cfg_done  out  1: all frames loaded and settle period elapsed.
REQ-011 SHALL have port cfg_err  out  1: sticky protocol error.
REQ-012 SHALL have port frames_loaded  out  $clog2(NUM_FRAMES+1): count of completed frames.
REQ-013 SHALL have ports rb_req  in  1, rb_addr  in  $clog2(NUM_FRAMES+1), rb_valid  out  1, and rb_data  out  WORD_W: readback request, frame index, response strobe and response data.

Function
REQ-014 SHALL implement states IDLE, LOAD, SETTLE, DONE and ERR, with cur as the current frame index.
REQ-015 IDLE: cfg_en==0 -> stay in IDLE; cfg_en==1<<0 -> go to LOAD with cur=0; any other value -> go to ERR.
REQ-016 LOAD transitions:
  - cfg_en==1<<cur -> stay in LOAD.
  - cfg_en==1<<(cur+1) with cur<NUM_FRAMES-1 -> cur+1, frames_loaded+1.
  - cfg_en==0 with cur==NUM_FRAMES-1 -> frames_loaded=NUM_FRAMES, go to SETTLE.
  - any other value, including multi-hot, skip, backward step, or early zero -> go to ERR.
REQ-017 SHALL write frame k with cfg_in on every cycle where the state is IDLE or LOAD, cfg_en is legal per REQ-015/016, and cfg_en[k]=1; a frame's final value is the last word presented while its enable bit was high.
REQ-018 SETTLE SHALL count HOLD_CYCLES cycles, then go to DONE; ff_en and cfg_done SHALL rise together on DONE entry.
REQ-019 DONE SHALL ignore cfg_en and cfg_in; frames are frozen until reset.
REQ-020 ERR SHALL be terminal until reset: cfg_err=1, ff_en=0, no frame writes; frames and frames_loaded hold their values.
REQ-021 Readback SHALL have 1-cycle latency: rb_req at edge N -> rb_valid=1 and rb_data=frame[rb_addr] after edge N+1; otherwise rb_valid=0.
REQ-022 rb_addr>=NUM_FRAMES SHALL return rb_data=0 with rb_valid=1.
REQ-023 Readback of a frame being written in the same cycle SHALL return the pre-write value.
REQ-024 Back-to-back rb_req SHALL be accepted every cycle, in any state.

Reset
REQ-025 When rst=0, asynchronously: state=IDLE, cur=0, all frames=0, frames_loaded=0, ff_en=0, cfg_done=0, cfg_err=0, rb_valid=0, rb_data=0.
REQ-026 Reset asserted mid-LOAD or mid-SETTLE SHALL discard partial configuration; loading restarts from IDLE after release.

Configuration
REQ-027 Macro CFG_READBACK_EN defined -> readback behaves per REQ-021..024.
REQ-028 Macro CFG_READBACK_EN undefined -> readback ports remain present; rb_valid=0 and rb_data=0 constantly; rb_req and rb_addr are ignored; no readback mux is synthesized.

Verification
REQ-029 Load: NUM_FRAMES=4, WORD_W=8, HOLD_CYCLES=3; loader drives words A5,3C,FF,01, holding each 2 cycles per enable, then cfg_en=0 -> frames_loaded=4, ff_en and cfg_done rise 3 cycles after cfg_en=0, frames_out=0x01FF3CA5.
REQ-030 Protocol error: during LOAD at cur=1, drive cfg_en=4'b1000 -> cfg_err=1 next cycle; frames 2..3 remain 0; ff_en stays 0.
REQ-031 Multi-hot and early zero: cfg_en=4'b0011 -> ERR; separately, cfg_en=0 at cur=2 -> ERR with frames_loaded=2.
REQ-032 Readback (CFG_READBACK_EN defined): after the load scenario, rb_req with rb_addr=2 -> next cycle rb_valid=1, rb_data=FF; rb_addr=7 -> rb_data=00; same-cycle write/read of frame 0 returns the old value.
REQ-033 Reset mid-operation: assert rst=0 during SETTLE -> all outputs zero immediately; reload with words 11,22,33,44 -> frames_out=0x44332211.
REQ-034 Readback compiled out (CFG_READBACK_EN undefined): rb_req pulses on any rb_addr -> rb_valid and rb_data remain 0.

Source files
------------

// File: rtl/config_frame_sink.sv
// Configuration frame sink: captures one-hot sequenced config words into frames, settles, then enables fabric flops.
// Optional readback port enabled by defining CFG_READBACK_EN.
module config_frame_sink #(
  parameter int unsigned WORD_W      = 224,
  parameter int unsigned NUM_FRAMES  = 245,
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic                                  clock,
  input  logic                                  rst,
  input  logic [WORD_W-1:0]                     cfg_in,
  input  logic [NUM_FRAMES-1:0]                 cfg_en,
  output logic [NUM_FRAMES*WORD_W-1:0]          frames_out,
  output logic                                  ff_en,
  output logic                                  cfg_done,
  output logic                                  cfg_err,
  output logic [$clog2(NUM_FRAMES+1)-1:0]       frames_loaded,
  input  logic                                  rb_req,
  input  logic [$clog2(NUM_FRAMES+1)-1:0]       rb_addr,
  output logic                                  rb_valid,
  output logic [WORD_W-1:0]                     rb_data
);

  localparam int unsigned IDX_W  = $clog2(NUM_FRAMES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_DONE, S_ERR} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      cur, cur_next, loaded_next;
  logic [HOLD_W-1:0]     hold_cnt, hold_next;
  logic                  write_c;
  logic [NUM_FRAMES-1:0] hot_cur, hot_nxt;

  // Protocol checker and sequencing; write_c marks cycles where cfg_en is a legal write.
  always_comb begin
    hot_cur     = NUM_FRAMES'(1) << cur;
    hot_nxt     = NUM_FRAMES'(1) << (cur + IDX_W'(1));
    state_next  = state;
    cur_next    = cur;
    loaded_next = frames_loaded;
    hold_next   = hold_cnt;
    write_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_en == NUM_FRAMES'(1)) begin
          state_next = S_LOAD;
          cur_next   = '0;
          write_c    = 1'b1;
        end else if (cfg_en != '0) begin
          state_next = S_ERR;
        end
      end
      S_LOAD: begin
        if (cfg_en == hot_cur) begin
          write_c = 1'b1;
        end else if ((32'(cur) < NUM_FRAMES - 1) && (cfg_en == hot_nxt)) begin
          cur_next    = cur + IDX_W'(1);
          loaded_next = frames_loaded + IDX_W'(1);
          write_c     = 1'b1;
        end else if ((32'(cur) == NUM_FRAMES - 1) && (cfg_en == '0)) begin
          state_next  = S_SETTLE;
          loaded_next = IDX_W'(NUM_FRAMES);
          hold_next   = '0;
        end else begin
          state_next = S_ERR;
        end
      end
      S_SETTLE: begin
        if (32'(hold_cnt) + 32'd1 >= HOLD_CYCLES) state_next = S_DONE;
        else hold_next = hold_cnt + HOLD_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cur           <= '0;
      frames_loaded <= '0;
      hold_cnt      <= '0;
      ff_en         <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state         <= state_next;
      cur           <= cur_next;
      frames_loaded <= loaded_next;
      hold_cnt      <= hold_next;
      ff_en         <= (state_next == S_DONE);
      cfg_done      <= (state_next == S_DONE);
      cfg_err       <= (state_next == S_ERR);
    end
  end

  // Frame storage: only the selected frame captures, and only on legal cycles.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      frames_out <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_FRAMES); k++) begin
        if (write_c && cfg_en[k]) frames_out[k*WORD_W +: WORD_W] <= cfg_in;
      end
    end
  end

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0] rb_sel_c;

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rb_sel_c = '0;
    for (int k = 0; k < int'(NUM_FRAMES); k++) begin
      if (rb_addr == IDX_W'(k)) rb_sel_c = frames_out[k*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      rb_valid <= rb_req;
      if (rb_req) rb_data <= rb_sel_c;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = ^{rb_req, rb_addr};
  assign rb_valid  = 1'b0;
  assign rb_data   = '0;
`endif

endmodule

// File: tb/tb_config_frame_sink.sv
// Self-checking bench for config_frame_sink (4 frames x 8 bits, 3 settle cycles) against a behavioural model.
module tb_config_frame_sink;

  localparam int unsigned NF = 4;
  localparam int unsigned WW = 8;
  localparam int unsigned HC = 3;

  logic          clock = 1'b0;
  logic          rst;
  logic [WW-1:0] cfg_in;
  logic [NF-1:0] cfg_en;
  logic [NF*WW-1:0] frames_out;
  logic          ff_en, cfg_done, cfg_err;
  logic [2:0]    frames_loaded;
  logic          rb_req;
  logic [2:0]    rb_addr;
  logic          rb_valid;
  logic [WW-1:0] rb_data;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_fr[NF];
  int         m_loaded, m_cur, m_settle;
  bit         m_active, m_err, m_done, m_rbv;
  logic [7:0] m_rbd;

  config_frame_sink #(.WORD_W(WW), .NUM_FRAMES(NF), .HOLD_CYCLES(HC)) dut (
    .clock(clock), .rst(rst), .cfg_in(cfg_in), .cfg_en(cfg_en),
    .frames_out(frames_out), .ff_en(ff_en), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .frames_loaded(frames_loaded), .rb_req(rb_req), .rb_addr(rb_addr),
    .rb_valid(rb_valid), .rb_data(rb_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NF); i++) m_fr[i] = 8'h00;
    m_loaded = 0; m_cur = 0; m_settle = 0;
    m_active = 0; m_err = 0; m_done = 0; m_rbv = 0; m_rbd = 8'h00;
  endtask

  task automatic model_step(input logic [3:0] en, input logic [7:0] din,
                            input logic req, input logic [2:0] addr);
`ifdef CFG_READBACK_EN
    m_rbv = req;
    if (req) begin
      if (int'(addr) < int'(NF)) m_rbd = m_fr[addr];
      else m_rbd = 8'h00;
    end
`else
    m_rbv = 0;
    m_rbd = 8'h00;
`endif
    if (m_err || m_done) return;
    if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) m_done = 1;
      return;
    end
    if (!m_active) begin
      if (en == 4'b0001) begin m_active = 1; m_cur = 0; m_fr[0] = din; end
      else if (en != 4'b0000) m_err = 1;
    end else if (en == 4'(1 << m_cur)) begin
      m_fr[m_cur] = din;
    end else if (m_cur < int'(NF) - 1 && en == 4'(1 << (m_cur + 1))) begin
      m_cur++; m_loaded++; m_fr[m_cur] = din;
    end else if (m_cur == int'(NF) - 1 && en == 4'b0000) begin
      m_loaded = NF; m_settle = HC; m_active = 0;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ff_en"},     32'(ff_en),         32'(m_done));
    check({tag, ".cfg_done"},  32'(cfg_done),      32'(m_done));
    check({tag, ".cfg_err"},   32'(cfg_err),       32'(m_err));
    check({tag, ".loaded"},    32'(frames_loaded), 32'(m_loaded));
    check({tag, ".frames"},    frames_out,         {m_fr[3], m_fr[2], m_fr[1], m_fr[0]});
    check({tag, ".rb_valid"},  32'(rb_valid),      32'(m_rbv));
    check({tag, ".rb_data"},   32'(rb_data),       32'(m_rbd));
  endtask

  task automatic cycle(input logic [3:0] en, input logic [7:0] din,
                       input logic req, input logic [2:0] addr, input string tag);
    cfg_en = en; cfg_in = din; rb_req = req; rb_addr = addr;
    model_step(en, din, req, addr);
    @(posedge clock); #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0; cfg_en = '0; cfg_in = '0; rb_req = 1'b0; rb_addr = '0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clock); #1;
    check_all("rst_hold");
    rst = 1'b1;
  endtask

  // Presents each frame's word for hold cycles (random 1..3 if hold==0); earlier words are noise.
  task automatic load_words(input logic [31:0] words, input int hold, input string tag);
    int h;
    for (int k = 0; k < int'(NF); k++) begin
      h = (hold == 0) ? int'($urandom_range(1, 3)) : hold;
      for (int j = 0; j < h; j++)
        cycle(4'(1 << k), (j == h - 1) ? words[k*8 +: 8] : 8'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), tag);
    end
  endtask

  initial begin
    rst = 1'b0; cfg_en = '0; cfg_in = '0; rb_req = 1'b0; rb_addr = '0;
    model_reset();
    @(posedge clock); #1;
    check_all("reset");
    do_reset();

    // Directed load A5,3C,FF,01 with two cycles per enable
    load_words(32'h01FF3CA5, 2, "load");
    cycle(4'h0, 8'h00, 1'b0, 3'd0, "settle0");
    cycle(4'h0, 8'h00, 1'b0, 3'd0, "settle1");
    cycle(4'h0, 8'h00, 1'b0, 3'd0, "settle2");
    check("settle_ff_en_low", 32'(ff_en), 32'd0);
    cycle(4'h0, 8'h00, 1'b0, 3'd0, "done");
    check("done_ff_en", 32'(ff_en), 32'd1);
    check("done_frames", frames_out, 32'h01FF3CA5);
    check("done_loaded", 32'(frames_loaded), 32'd4);
    for (int i = 0; i < 4; i++)
      cycle(4'($urandom), 8'($urandom), 1'b0, 3'd0, "done_ignore");
    cycle(4'h1, 8'h77, 1'b1, 3'd2, "rb_addr2");
`ifdef CFG_READBACK_EN
    check("rb2_data", 32'(rb_data), 32'hFF);
    check("rb2_valid", 32'(rb_valid), 32'd1);
`else
    check("rb2_off", 32'({rb_valid, rb_data}), 32'd0);
`endif
    cycle(4'h0, 8'h00, 1'b1, 3'd7, "rb_addr7");
    check("rb7_data", 32'(rb_data), 32'h00);
    for (int i = 0; i < 6; i++)
      cycle(4'h0, 8'h00, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rb_rand");

    // Same-cycle write and read of frame 0 returns the old value
    do_reset();
    cycle(4'h1, 8'h5A, 1'b0, 3'd0, "wr0");
    cycle(4'h1, 8'hC3, 1'b1, 3'd0, "wr_rd0");
`ifdef CFG_READBACK_EN
    check("wr_rd0_old", 32'(rb_data), 32'h5A);
`endif
    cycle(4'h1, 8'h00, 1'b1, 3'd0, "rd0_new");

    // Reset during SETTLE, then reload 11,22,33,44
    load_words(32'($urandom), 0, "pre_rst");
    cycle(4'h0, 8'h00, 1'b0, 3'd0, "pre_settle");
    cycle(4'h0, 8'h00, 1'b0, 3'd0, "pre_settle1");
    do_reset();
    check("rst_frames_zero", frames_out, 32'h0);
    load_words(32'h44332211, 1, "reload");
    for (int i = 0; i < int'(HC) + 1; i++) cycle(4'h0, 8'h00, 1'b0, 3'd0, "reload_settle");
    check("reload_frames", frames_out, 32'h44332211);
    check("reload_done", 32'(cfg_done), 32'd1);

    // Skip at cur=1
    do_reset();
    cycle(4'h1, 8'hAB, 1'b0, 3'd0, "skip_f0");
    cycle(4'h2, 8'hCD, 1'b0, 3'd0, "skip_f1");
    cycle(4'h8, 8'hEF, 1'b0, 3'd0, "skip_err");
    check("skip_cfg_err", 32'(cfg_err), 32'd1);
    for (int i = 0; i < 3; i++) cycle(4'($urandom), 8'($urandom), 1'b0, 3'd0, "err_hold");
    check("skip_hi_zero", 32'(frames_out[31:16]), 32'h0);
    check("skip_ff_en", 32'(ff_en), 32'd0);

    // Multi-hot from IDLE
    do_reset();
    cycle(4'h3, 8'h99, 1'b0, 3'd0, "multihot");
    check("multihot_err", 32'(cfg_err), 32'd1);
    check("multihot_frames", frames_out, 32'h0);

    // Early zero at cur=2
    do_reset();
    cycle(4'h1, 8'h10, 1'b0, 3'd0, "ez_f0");
    cycle(4'h2, 8'h20, 1'b0, 3'd0, "ez_f1");
    cycle(4'h4, 8'h30, 1'b0, 3'd0, "ez_f2");
    cycle(4'h0, 8'h40, 1'b0, 3'd0, "ez_err");
    check("ez_loaded", 32'(frames_loaded), 32'd2);
    check("ez_cfg_err", 32'(cfg_err), 32'd1);

    // Randomized sessions with a random corrupt enable injected part-way
    for (int s = 0; s < 20; s++) begin
      int stop_at;
      do_reset();
      stop_at = int'($urandom_range(0, 12));
      for (int c = 0; c < 14; c++) begin
        logic [3:0] en;
        if (c == stop_at) en = 4'($urandom);
        else if (m_active) en = ($urandom_range(0, 2) == 0 && m_cur < 3) ? 4'(1 << (m_cur + 1))
                                 : (m_cur == 3 && $urandom_range(0, 3) == 0) ? 4'h0 : 4'(1 << m_cur);
        else en = (m_settle > 0 || m_done) ? 4'($urandom) : 4'h1;
        cycle(en, 8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
